// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment capture path: glyph table,
// decode result type and digit-to-nibble placement.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  // Active-low segment patterns [6:0] = g..a for hex values 0..F.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  // Digit 0 occupies the most significant nibble of the display word.
  function automatic int unsigned nib_lsb(input int unsigned digit);
    return (NUM_DIGITS - 1 - digit) * 4;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: active-low 7-segment pattern -> hex nibble,
// with flags for a legal glyph and for an all-off (blank) digit.
module seg7_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] pat_i,
  output seg_dec_t   dec_o
);

  // Table search; nibble is only meaningful when legal is set.
  always_comb begin
    dec_o       = '0;
    dec_o.blank = (pat_i == SEG_BLANK);
    for (int unsigned g = 0; g < 16; g++) begin
      if (pat_i == SEG_GLYPH[g]) begin
        dec_o.legal  = 1'b1;
        dec_o.nibble = 4'(g);
      end
    end
  end

endmodule

// File: rtl/seg_capture.sv
// Receive side of a 6-digit multiplexed seven-segment display: synchronizes
// the scan lines, waits for them to settle, decodes each selected digit and
// reassembles the display word with validity, error, frame and stale status.
module seg_capture
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   seg_sel,
  input  logic [7:0]              seg_data,
  output logic [4*NUM_DIGITS-1:0] dis_data,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   err_code,
  output logic                    frame_valid,
  output logic                    frame_done,
  output logic                    stale
);

  localparam int unsigned IW   = NUM_DIGITS + 8;
  localparam int unsigned CW   = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned XW   = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE         = {{NUM_DIGITS{1'b1}}, 8'hFF};

  logic [IW-1:0]           sync1_q, sync2_q, prev_q;
  logic [CW-1:0]           settle_q, settle_d;
  logic                    sampled_q, sampled_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] dis_q, dis_d;
  logic [NUM_DIGITS-1:0]   dv_q, dv_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    fv_q, fv_d;
  logic                    fd_q, fd_d;
  logic                    stale_q, stale_d;

  logic                    changed, fire, accept;
  logic [3:0]              nlow;
  logic [XW-1:0]           sel_idx;
  seg_dec_t                dec;

  seg7_glyph_decode u_dec (
    .pat_i (sync2_q[6:0]),
    .dec_o (dec)
  );

  // Settle filter, select decode and per-sample register updates.
  // The dp bit takes part in change detection but never in decoding.
  always_comb begin
    changed   = (sync2_q != prev_q);
    fire      = !changed && (settle_q == SETTLE_LAST) && !sampled_q;
    settle_d  = settle_q;
    sampled_d = sampled_q;
    if (changed) begin
      settle_d  = '0;
      sampled_d = 1'b0;
    end else if (settle_q == SETTLE_LAST) begin
      sampled_d = 1'b1;
    end else begin
      settle_d = settle_q + CW'(1);
    end

    nlow    = '0;
    sel_idx = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (!sync2_q[8 + d]) begin
        nlow    = nlow + 4'd1;
        sel_idx = XW'(d);
      end
    end
    accept = fire && (nlow == 4'd1);

    dis_d   = dis_q;
    dv_d    = dv_q;
    err_d   = err_q;
    seen_d  = seen_q;
    fv_d    = fv_q;
    fd_d    = 1'b0;
    stale_d = stale_q;
    tmo_d   = tmo_q;

    if (accept) begin
      if (dec.legal) begin
        dis_d[nib_lsb(sel_idx) +: 4] = dec.nibble;
        dv_d[sel_idx]                = 1'b1;
        err_d[sel_idx]               = 1'b0;
      end else begin
        dv_d[sel_idx]  = 1'b0;
        err_d[sel_idx] = !dec.blank;
      end
      seen_d[sel_idx] = 1'b1;
      tmo_d           = '0;
      stale_d         = 1'b0;
      if (seen_d == '1) begin
        fd_d   = 1'b1;
        fv_d   = &dv_d;
        seen_d = '0;
      end
    end else if (tmo_q == TIMEOUT_LAST) begin
      stale_d = 1'b1;
      dv_d    = '0;
      fv_d    = 1'b0;
      seen_d  = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // State registers with synchronous reset to the idle/cleared condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= IDLE;
      sync2_q   <= IDLE;
      prev_q    <= IDLE;
      settle_q  <= '0;
      sampled_q <= 1'b0;
      tmo_q     <= '0;
      seen_q    <= '0;
      dis_q     <= '0;
      dv_q      <= '0;
      err_q     <= '0;
      fv_q      <= 1'b0;
      fd_q      <= 1'b0;
      stale_q   <= 1'b0;
    end else begin
      sync1_q   <= {seg_sel, seg_data};
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      settle_q  <= settle_d;
      sampled_q <= sampled_d;
      tmo_q     <= tmo_d;
      seen_q    <= seen_d;
      dis_q     <= dis_d;
      dv_q      <= dv_d;
      err_q     <= err_d;
      fv_q      <= fv_d;
      fd_q      <= fd_d;
      stale_q   <= stale_d;
    end
  end

  assign dis_data    = dis_q;
  assign digit_valid = dv_q;
  assign err_code    = err_q;
  assign frame_valid = fv_q;
  assign frame_done  = fd_q;
  assign stale       = stale_q;

endmodule
